// File: rtl/byte_drain.sv
// Byte buffer between an upstream byte shifter and a consumer: circular storage,
// fill level, full/valid flags and a sticky flag recording dropped writes.
module byte_drain #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  input  logic          flush,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   level_q, level_d;
  logic          overflow_q, overflow_d;

  logic push;
  logic pop;
  logic drop;

  assign full     = (level_q == FULL_LEVEL);
  assign rd_valid = (level_q != '0);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign rd_data  = mem_q[rp_q];

  // A full buffer still takes a byte when the consumer frees a slot on the same edge.
  assign pop  = rd_valid & rd_ready;
  assign push = wr_en & (~full | pop);
  assign drop = wr_en & full & ~pop;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush) begin
      wp_d       = '0;
      rp_d       = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
      if (drop) overflow_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; its contents are only
  // observable through rd_data while level is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wp_q] <= wr_data;
  end

endmodule

// File: tb/tb_byte_drain.sv
// Directed bench for byte_drain at DEPTH=16: single byte, underflow, fill/overflow,
// full push+pop, wrap-around streaming, flush and asynchronous reset.
module tb_byte_drain;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          flush;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW:0]   level;
  logic          overflow;

  int total = 0;
  int bad   = 0;

  byte_drain #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .flush    (flush),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_ready = 1'b0; flush = 1'b0; wr_data = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    #12;
    total++; if (level !== 5'd0)    begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    total++; if (full !== 1'b0)     begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    wr_en = 1'b1; wr_data = 8'hA5; tick(); idle();
    total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", rd_valid); end
    total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", rd_data); end
    total++; if (level !== 5'd1)    begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
    tick();
    total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL single_hold got=%h exp=a5", rd_data); end
    rd_ready = 1'b1; tick(); idle();
    total++; if (level !== 5'd0)    begin bad++; $display("FAIL single_pop_level got=%0d exp=0", level); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%b exp=0", rd_valid); end
  endtask

  task automatic test_empty_edges();
    rd_ready = 1'b1; tick(); tick();
    total++; if (level !== 5'd0) begin bad++; $display("FAIL underflow_level got=%0d exp=0", level); end
    wr_en = 1'b1; wr_data = 8'h3E; tick(); idle();
    total++; if (level !== 5'd1)    begin bad++; $display("FAIL empty_pushpop_level got=%0d exp=1", level); end
    total++; if (rd_data !== 8'h3E) begin bad++; $display("FAIL empty_pushpop_data got=%h exp=3e", rd_data); end
    rd_ready = 1'b1; tick(); idle();
    total++; if (level !== 5'd0) begin bad++; $display("FAIL empty_drain_level got=%0d exp=0", level); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); tick();
    end
    total++; if (full !== 1'b1)     begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_early got=%b exp=0", overflow); end
    wr_data = 8'h10; tick(); idle();
    total++; if (level !== 5'd16)   begin bad++; $display("FAIL ovf_level got=%0d exp=16", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin bad++; $display("FAIL drain_%0d got=%h/%b exp=%h/1", i, rd_data, rd_valid, 8'(i)); end
      tick();
    end
    idle();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0 (0x10 leaked)", rd_valid); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'hC0 + 8'(i); tick();
    end
    idle();
    total++; if (level !== 5'd5 || overflow !== 1'b1) begin bad++; $display("FAIL flush_pre got=%0d/%b exp=5/1", level, overflow); end
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h77; rd_ready = 1'b1; tick(); idle();
    total++; if (level !== 5'd0)    begin bad++; $display("FAIL flush_level got=%0d exp=0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf got=%b exp=0", overflow); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", rd_valid); end
    tick();
    total++; if (level !== 5'd0) begin bad++; $display("FAIL flush_stored got=%0d exp=0", level); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'h20 + 8'(i); tick();
    end
    rd_ready = 1'b1; wr_data = 8'h55; tick(); idle();
    total++; if (level !== 5'd16)   begin bad++; $display("FAIL fpp_level got=%0d exp=16", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf got=%b exp=0", overflow); end
    rd_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      total++; if (rd_data !== 8'h20 + 8'(i)) begin bad++; $display("FAIL fpp_drain_%0d got=%h exp=%h", i, rd_data, 8'h20 + 8'(i)); end
      tick();
    end
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h55) begin bad++; $display("FAIL fpp_last got=%h/%b exp=55/1", rd_data, rd_valid); end
    tick(); idle();
    total++; if (level !== 5'd0) begin bad++; $display("FAIL fpp_empty got=%0d exp=0", level); end
  endtask

  task automatic test_wrap();
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); tick();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i) || level !== 5'd1) begin
        bad++; $display("FAIL wrap_%0d got=%h/%b/%0d exp=%h/1/1", i, rd_data, rd_valid, level, 8'(i));
      end
    end
    wr_en = 1'b0; tick(); idle();
    total++; if (level !== 5'd0) begin bad++; $display("FAIL wrap_end got=%0d exp=0", level); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_data = 8'h90 + 8'(i); tick();
    end
    idle();
    total++; if (level !== 5'd7) begin bad++; $display("FAIL arst_pre got=%0d exp=7", level); end
    #2 rst = 1'b1;
    #1;
    total++; if (level !== 5'd0)    begin bad++; $display("FAIL arst_level got=%0d exp=0", level); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", rd_valid); end
    total++; if (full !== 1'b0)     begin bad++; $display("FAIL arst_full got=%b exp=0", full); end
    @(negedge clk); rst = 1'b0;
    wr_en = 1'b1; wr_data = 8'h3C; tick(); idle();
    total++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C || level !== 5'd1) begin
      bad++; $display("FAIL arst_write got=%h/%b/%0d exp=3c/1/1", rd_data, rd_valid, level);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_empty_edges();
    test_fill_overflow();
    test_flush();
    test_full_push_pop();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_drain.md
BYTE_DRAIN -- requirements
Module: byte_drain

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning storage depth in bytes; legal values are powers of two from 2 to 256.
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), meaning pointer width; it is derived from DEPTH and is not overridden.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_en  input  1  write strobe from the upstream byte shifter.
REQ-006 wr_data  input  8  byte to store; sampled when wr_en=1.
REQ-007 full  output  1  high when level==DEPTH.
REQ-008 flush  input  1  synchronous clear of all stored bytes and the overflow flag.
REQ-009 rd_data  output  8  oldest stored byte; valid only while rd_valid=1.
REQ-010 rd_valid  output  1  high when level!=0.
REQ-011 rd_ready  input  1  consumer accept; a byte pops on a clock edge where rd_valid=1 and rd_ready=1.
REQ-012 level  output  AW+1  number of bytes currently stored, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag; set when a write is dropped.

Function
REQ-014 SHALL store bytes in a DEPTH-entry register array with write pointer wp and read pointer rp, each AW bits wide, using modulo-DEPTH wrap-around.
REQ-015 SHALL define push as wr_en & (~full | pop), and pop as rd_valid & rd_ready.
REQ-016 SHALL, on push, write mem[wp]=wr_data and set wp=wp+1 mod DEPTH.
REQ-017 SHALL, on pop, set rp=rp+1 mod DEPTH.
REQ-018 SHALL update level by +1 on push only, -1 on pop only, and leave it unchanged on both or neither.
REQ-019 SHALL drive rd_data combinationally from mem[rp], giving 1-cycle write-to-read latency: a byte written at edge k into an empty buffer shows rd_valid=1 and rd_data=byte immediately after edge k.
REQ-020 SHALL accept a write while full only if a pop occurs on the same edge; level then stays at DEPTH.
REQ-021 SHALL, on wr_en=1 with full=1 and no pop, drop the byte, leave mem, wp and level unchanged, and set overflow=1.
REQ-022 SHALL hold overflow at 1 until flush or rst.
REQ-023 SHALL ignore rd_ready when rd_valid=0: no pointer change, no underflow.
REQ-024 SHALL, on a push and pop in the same edge while empty, perform no pop; the written byte becomes visible after the edge with level=1.
REQ-025 SHALL, on flush=1, set wp=0, rp=0, level=0 and overflow=0, and ignore any wr_en or pop on that edge.
REQ-026 SHALL keep rd_data stable while rd_valid=1 and rd_ready=0.
REQ-027 SHALL deliver bytes in strict write order with no duplication or loss, except for the drops defined in REQ-021.

Reset
REQ-028 SHALL, on rst=1, immediately and without waiting for clk force wp=0, rp=0, level=0, overflow=0, rd_valid=0 and full=0.
REQ-029 SHALL NOT reset memory contents; rd_data is don't-care while rd_valid=0.
REQ-030 SHALL abandon any in-flight operation on rst assertion mid-stream, and SHALL accept a write on the first rising edge after rst deasserts.

Verification
REQ-031 Single byte: write 0xA5 with rd_ready=0 -> next cycle shows rd_valid=1, rd_data=0xA5, level=1; then raise rd_ready for one edge -> level=0, rd_valid=0.
REQ-032 Fill and overflow (DEPTH=16): write 0x00..0x0F, then 0x10 with no pop -> full=1, level=16, overflow=1; drain all 16 -> reads 0x00..0x0F in order, 0x10 never appears.
REQ-033 Full with simultaneous push and pop: while full, write 0x55 with rd_ready=1 -> level stays 16, overflow stays 0, and 0x55 is read last after draining.
REQ-034 Wrap-around: stream 40 bytes 0x00..0x27 with rd_ready=1 at all times -> each byte appears the cycle after its write, level never exceeds 1, order is preserved.
REQ-035 Flush: with level=5 and overflow=1, assert flush together with wr_en=1 and wr_data=0x77 -> next cycle level=0, overflow=0, rd_valid=0, and 0x77 is not stored.
REQ-036 Async reset mid-stream: with level=7, assert rst between clock edges -> level=0, rd_valid=0 and full=0 before the next edge; after deasserting rst, write 0x3C -> reads back 0x3C.
